// File: rtl/cgra_pkg.sv
// Shared types and constants for the CGRA column memory path.
package cgra_pkg;

    localparam int unsigned CGRA_MEM_ADDR_WIDTH = 32;
    localparam int unsigned CGRA_DP_WIDTH       = 32;

    typedef struct packed {
        logic                     wen;
        logic                     ind;
        logic [CGRA_DP_WIDTH-1:0] add;
        logic [CGRA_DP_WIDTH-1:0] wdata;
    } cgra_mem_req_t;

endpackage

// File: rtl/cgra_outst_fifo.sv
// In-order tracker of outstanding bus transactions; each entry holds one is_read tag.
module cgra_outst_fifo import cgra_pkg::*; #(
    parameter int unsigned Depth = 2,
    parameter int unsigned CntW  = $clog2(Depth + 1)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            push_i,
    input  logic            push_tag_i,
    input  logic            pop_i,
    input  logic            flush_tag_i,
    output logic            head_tag_o,
    output logic            empty_o,
    output logic            full_o,
    output logic [CntW-1:0] count_o
);

    logic [Depth-1:0] tag_q, tag_d;
    logic [CntW-1:0]  cnt_q, cnt_d;

    // Entry 0 is always the head; a pop shifts the queue down by one.
    always_comb begin
        tag_d = tag_q;
        cnt_d = cnt_q;
        if (pop_i && (cnt_q != '0)) begin
            tag_d = tag_q >> 1;
            cnt_d = cnt_q - 1'b1;
        end
        if (push_i && (cnt_d < CntW'(Depth))) begin
            for (int i = 0; i < Depth; i++) begin
                if (CntW'(i) == cnt_d) begin
                    tag_d[i] = push_tag_i;
                end
            end
            cnt_d = cnt_d + 1'b1;
        end
        if (flush_tag_i) begin
            tag_d = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tag_q <= '0;
            cnt_q <= '0;
        end else begin
            tag_q <= tag_d;
            cnt_q <= cnt_d;
        end
    end

    assign head_tag_o = tag_q[0];
    assign empty_o    = (cnt_q == '0);
    assign full_o     = (cnt_q == CntW'(Depth));
    assign count_o    = cnt_q;

endmodule

// File: rtl/cgra_col_mem_port.sv
// Bridges one CGRA column memory interface to an OBI master port, with a local
// auto-increment address pointer and in-order response tracking.
module cgra_col_mem_port import cgra_pkg::*; #(
    parameter int unsigned DP_WIDTH   = CGRA_DP_WIDTH,
    parameter int unsigned ADDR_WIDTH = CGRA_MEM_ADDR_WIDTH,
    parameter int unsigned MAX_OUTST  = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  col_rst_i,
    input  logic                  ptr_load_i,
    input  logic [ADDR_WIDTH-1:0] ptr_val_i,
    input  logic [ADDR_WIDTH-1:0] stride_i,
    input  logic                  cgra_req_i,
    input  logic                  cgra_wen_i,
    input  logic                  cgra_ind_i,
    input  logic [DP_WIDTH-1:0]   cgra_add_i,
    input  logic [DP_WIDTH-1:0]   cgra_wdata_i,
    output logic                  cgra_gnt_o,
    output logic                  cgra_rvalid_o,
    output logic [DP_WIDTH-1:0]   cgra_rdata_o,
    output logic                  bus_req_o,
    input  logic                  bus_gnt_i,
    output logic [ADDR_WIDTH-1:0] bus_addr_o,
    output logic                  bus_we_o,
    output logic [DP_WIDTH/8-1:0] bus_be_o,
    output logic [DP_WIDTH-1:0]   bus_wdata_o,
    input  logic                  bus_rvalid_i,
    input  logic [DP_WIDTH-1:0]   bus_rdata_i,
    output logic                  busy_o,
    output logic                  err_o
);

    localparam int unsigned OffW = $clog2(DP_WIDTH / 8);
    localparam int unsigned CntW = $clog2(MAX_OUTST + 1);

    cgra_mem_req_t         col_req;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic                  err_q, err_d;
    logic [ADDR_WIDTH-1:0] raw_addr;
    logic                  misalign;
    logic                  head_is_read, fifo_empty, fifo_full, pop;
    logic [CntW-1:0]       outst_cnt;

    assign col_req = '{wen: cgra_wen_i, ind: cgra_ind_i, add: cgra_add_i, wdata: cgra_wdata_i};

    assign raw_addr = col_req.ind ? col_req.add[ADDR_WIDTH-1:0] : ptr_q;
    assign misalign = |raw_addr[OffW-1:0];

    assign bus_req_o   = cgra_req_i & ~fifo_full & ~col_rst_i;
    assign bus_addr_o  = {raw_addr[ADDR_WIDTH-1:OffW], {OffW{1'b0}}};
    assign bus_we_o    = ~col_req.wen;
    assign bus_be_o    = '1;
    assign bus_wdata_o = col_req.wdata;
    assign cgra_gnt_o  = bus_req_o & bus_gnt_i;

    // Responses drain even during a column restart, but are never forwarded then.
    assign pop           = bus_rvalid_i & ~fifo_empty;
    assign cgra_rvalid_o = pop & head_is_read & ~col_rst_i;
    assign cgra_rdata_o  = cgra_rvalid_o ? bus_rdata_i : '0;

    assign busy_o = (outst_cnt != '0);
    assign err_o  = err_q;

    cgra_outst_fifo #(
        .Depth (MAX_OUTST),
        .CntW  (CntW)
    ) u_outst_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (cgra_gnt_o),
        .push_tag_i  (col_req.wen),
        .pop_i       (pop),
        .flush_tag_i (col_rst_i),
        .head_tag_o  (head_is_read),
        .empty_o     (fifo_empty),
        .full_o      (fifo_full),
        .count_o     (outst_cnt)
    );

    always_comb begin
        ptr_d = ptr_q;
        err_d = err_q;
        if (col_rst_i) begin
            ptr_d = '0;
            err_d = 1'b0;
        end else begin
            if (ptr_load_i) begin
                ptr_d = ptr_val_i;
            end else if (cgra_gnt_o && !col_req.ind) begin
                ptr_d = ptr_q + stride_i;
            end
            if ((bus_req_o && misalign) || (bus_rvalid_i && fifo_empty)) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q <= '0;
            err_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
            err_q <= err_d;
        end
    end

endmodule
